// File: rtl/uart_rx_if.sv
// Receiver-side UART signal bundle: line and enable in, received word plus status strobes out.
// The master modport is the side that drives the line; the slave modport is the receiver.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_en;
    logic                 rx_serial;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_busy;
    logic                 rx_done;
    logic                 rx_error;

    modport master (
        output rx_en,
        output rx_serial,
        input  rx_data,
        input  rx_busy,
        input  rx_done,
        input  rx_error
    );

    modport slave (
        input  rx_en,
        input  rx_serial,
        output rx_data,
        output rx_busy,
        output rx_done,
        output rx_error
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_BITS data bits LSB first, one stop bit, each sampled mid-bit.
// Latency: rx_done about 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after the start edge.
// Backpressure: none; the serial line cannot be stalled, so each word is offered once with rx_done.
module uart_rx #(
    parameter int BAUD_RATE = 9600,
    parameter int CLK_FREQ  = 100_000_000,
    parameter int DATA_BITS = 8
) (
    input  logic     clk,
    input  logic     arst_n,
    uart_rx_if.slave rx
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] data_q;
    logic                 done_q;
    logic                 err_q;
    logic                 tc;
    logic                 sample_bit;
    logic                 frame_ok;
    logic                 frame_bad;

    // Synchronizer and edge history idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            state   <= IDLE;
        end else begin
            rx_meta <= rx.rx_serial;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            state   <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tc         = 1'b0;
        sample_bit = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (rx.rx_en && rx_prev && !rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                tc = (baud_cnt == HALF_TC);
                if (tc) begin
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                tc = (baud_cnt == BIT_TC);
                if (tc) begin
                    sample_bit = 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                tc = (baud_cnt == BIT_TC);
                if (tc) begin
                    state_nxt = IDLE;
                    frame_ok  = rx_s;
                    frame_bad = !rx_s;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Baud counter restarts on every state entry and on every bit boundary inside DATA.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if ((state_nxt != state) || tc) begin
                baud_cnt <= '0;
            end else if (state != IDLE) begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end

            if ((state == START) && (state_nxt == DATA)) begin
                bit_idx <= '0;
            end else if (sample_bit) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end

            if (sample_bit) begin
                shift[bit_idx] <= rx_s;
            end

            if (frame_ok) begin
                data_q <= shift;
            end
            done_q <= frame_ok | frame_bad;
            err_q  <= frame_bad;
        end
    end

    assign rx.rx_data  = data_q;
    assign rx.rx_busy  = (state != IDLE);
    assign rx.rx_done  = done_q;
    assign rx.rx_error = err_q;
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are bit-banged onto the line and every rx_done is
// scored against a queue of expected words kept from the frame-level rules.
module tb_uart_rx;
    localparam int CLK_FREQ  = 100_000_000;
    localparam int BAUD_RATE = 6_250_000;
    localparam int DATA_BITS = 8;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = CPB / 2;
    localparam int LAT_NOM   = 2 + HALF + (DATA_BITS + 1) * CPB;
    localparam int BUSY_NOM  = HALF + (DATA_BITS + 1) * CPB;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic arst_n;

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(DATA_BITS)) ifc();

    uart_rx #(
        .BAUD_RATE(BAUD_RATE),
        .CLK_FREQ (CLK_FREQ),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .rx    (ifc.slave)
    );

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         cyc       = 0;
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    int         done_cyc  = 0;
    int         busy_run  = 0;
    int         last_busy = 0;
    logic [7:0] model_data = 8'h00;
    logic       prev_done  = 1'b0;

    int         t0, d0, e0, lat, n_exp, gap;
    logic [7:0] v;
    logic       stop_b, en_b, drop_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic drive_bit(input logic b);
        ifc.rx_serial = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // An error frame is followed by one idle-high bit so the next start has a falling edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic expect_it);
        exp_t e;
        if (expect_it) begin
            e.data = d;
            e.err  = ~stop;
            exp_q.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
        drive_bit(stop);
        if (!stop) drive_bit(1'b1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (arst_n) begin
            if (prev_done) check("done_pulse_width", 32'(ifc.rx_done), 32'd0);
            if (ifc.rx_error) check("error_with_done", 32'(ifc.rx_done), 32'd1);
            if (ifc.rx_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    if (ifc.rx_error) err_cnt++;
                    check("done_error", 32'(ifc.rx_error), 32'(mon_e.err));
                    if (!mon_e.err) model_data = mon_e.data;
                    check("done_data", 32'(ifc.rx_data), 32'(model_data));
                end
            end
            if (ifc.rx_busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy = busy_run;
                busy_run  = 0;
            end
        end else begin
            busy_run = 0;
        end
        prev_done = ifc.rx_done;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.rx_en     = 1'b1;
        ifc.rx_serial = 1'b1;
        arst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  32'(ifc.rx_data),  32'd0);
        check("rst_busy",  32'(ifc.rx_busy),  32'd0);
        check("rst_done",  32'(ifc.rx_done),  32'd0);
        check("rst_error", 32'(ifc.rx_error), 32'd0);
        arst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Single clean frame: data, latency and busy window.
        t0 = cyc;
        d0 = done_cnt;
        last_busy = 0;
        send_frame(8'h55, 1'b1, 1'b1);
        lat = done_cyc - t0;
        check("s1_done_count", 32'(done_cnt - d0), 32'd1);
        check("s1_data", 32'(ifc.rx_data), 32'h55);
        check("s1_latency", 32'((lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2) ? LAT_NOM : lat), 32'(LAT_NOM));
        check("s1_busy_len",
              32'((last_busy >= BUSY_NOM - 3 && last_busy <= BUSY_NOM + 3) ? BUSY_NOM : last_busy),
              32'(BUSY_NOM));

        // Back-to-back frames with a single-cycle gap.
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'hAF, 1'b1, 1'b1);
        check("s2_first_data", 32'(ifc.rx_data), 32'hAF);
        @(posedge clk);
        #1;
        send_frame(8'h00, 1'b1, 1'b1);
        check("s2_done_count", 32'(done_cnt - d0), 32'd2);
        check("s2_data", 32'(ifc.rx_data), 32'h00);
        check("s2_no_error", 32'(err_cnt - e0), 32'd0);

        // Short low glitch is rejected at the mid-start sample.
        d0 = done_cnt;
        last_busy = 0;
        ifc.rx_serial = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ifc.rx_serial = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("s3_busy_len",
              32'((last_busy >= HALF - 2 && last_busy <= HALF + 3) ? HALF : last_busy), 32'(HALF));
        check("s3_no_done", 32'(done_cnt - d0), 32'd0);
        check("s3_data_held", 32'(ifc.rx_data), 32'h00);
        check("s3_idle", 32'(ifc.rx_busy), 32'd0);

        // Framing error: strobe pair, word kept.
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 1'b1);
        check("s4_done_count", 32'(done_cnt - d0), 32'd1);
        check("s4_error_count", 32'(err_cnt - e0), 32'd1);
        check("s4_data_held", 32'(ifc.rx_data), 32'h00);

        // Break: one framing error, then no retrigger while the line stays low.
        d0 = done_cnt;
        e0 = err_cnt;
        exp_q.push_back(exp_t'{8'h00, 1'b1});
        ifc.rx_serial = 1'b0;
        repeat (30 * CPB) @(posedge clk);
        #1;
        check("brk_done_count", 32'(done_cnt - d0), 32'd1);
        check("brk_error_count", 32'(err_cnt - e0), 32'd1);
        check("brk_idle", 32'(ifc.rx_busy), 32'd0);
        ifc.rx_serial = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;

        // Reset in the middle of bit 4 of a frame discards it.
        d0 = done_cnt;
        v  = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(v[i]);
        ifc.rx_serial = v[4];
        repeat (HALF) @(posedge clk);
        #1;
        arst_n = 1'b0;
        #1;
        check("s5_rst_data",  32'(ifc.rx_data),  32'd0);
        check("s5_rst_busy",  32'(ifc.rx_busy),  32'd0);
        check("s5_rst_done",  32'(ifc.rx_done),  32'd0);
        check("s5_rst_error", 32'(ifc.rx_error), 32'd0);
        model_data    = 8'h00;
        ifc.rx_serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        arst_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("s5_no_done", 32'(done_cnt - d0), 32'd0);
        send_frame(8'h81, 1'b1, 1'b1);
        check("s5_data", 32'(ifc.rx_data), 32'h81);

        // Start edge ignored while disabled.
        d0 = done_cnt;
        last_busy = 0;
        ifc.rx_en = 1'b0;
        send_frame(8'h12, 1'b1, 1'b0);
        check("s6_no_busy", 32'(last_busy + busy_run), 32'd0);
        check("s6_no_done", 32'(done_cnt - d0), 32'd0);
        ifc.rx_en = 1'b1;
        send_frame(8'h34, 1'b1, 1'b1);
        check("s6_data", 32'(ifc.rx_data), 32'h34);

        // Random frames: data, stop errors, disabled frames, mid-frame enable drops, gaps.
        d0    = done_cnt;
        n_exp = 0;
        for (int k = 0; k < 30; k++) begin
            v      = 8'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 7) != 0);
            en_b   = ($urandom_range(0, 5) != 0);
            drop_b = ($urandom_range(0, 2) == 0);
            gap    = $urandom_range(0, 3);
            ifc.rx_en = en_b;
            if (en_b) n_exp++;
            if (en_b && drop_b) begin
                fork
                    send_frame(v, stop_b, 1'b1);
                    begin
                        repeat ($urandom_range(CPB, 8 * CPB)) @(posedge clk);
                        #1;
                        ifc.rx_en = 1'b0;
                    end
                join
            end else begin
                send_frame(v, stop_b, en_b);
            end
            ifc.rx_en = 1'b1;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("rand_done_count", 32'(done_cnt - d0), 32'(n_exp));
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_data_held", 32'(ifc.rx_data), 32'(model_data));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
